// File: rtl/booth_mult_pkg.sv
// Shared definitions for the Booth multiplier: FSM states, Booth op codes and
// the recoding helper used by the datapath.
package booth_mult_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_t;

    // Radix-2 recoding of {Q[0], q_1}: 01 adds M, 10 subtracts M.
    function automatic booth_op_t booth_decode(input logic [1:0] bits);
        case (bits)
            2'b01:   return BOOTH_ADD;
            2'b10:   return BOOTH_SUB;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/rca.sv
// Ripple-carry adder from the adder library; carry chain kept in a local
// variable so the chain is a single combinational pass.
module rca #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum
);

    logic carry;

    always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/booth_mult.sv
// Sequential radix-2 Booth signed multiplier, WIDTH x WIDTH -> 2*WIDTH, one
// add/sub-and-shift per cycle with valid/ready handshakes on both sides.
module booth_mult
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [WIDTH:0]   m_r, a_r, add_b, sum, a_op, a_sh;
    logic [WIDTH-1:0] q_r, q_sh;
    logic             q_1;
    logic [CW-1:0]    count;
    booth_op_t        op;
    logic             sub, accept, last;

    // A is one bit wider than the operands so A - M cannot overflow at M = -2^(WIDTH-1).
    assign op    = booth_decode({q_r[0], q_1});
    assign sub   = (op == BOOTH_SUB);
    assign add_b = sub ? ~m_r : m_r;

    rca #(.WIDTH(WIDTH + 1)) u_rca (
        .a   (a_r),
        .b   (add_b),
        .cin (sub),
        .sum (sum)
    );

    assign a_op   = (op == BOOTH_NOP) ? a_r : sum;
    assign a_sh   = {a_op[WIDTH], a_op[WIDTH:1]};
    assign q_sh   = {a_op[0], q_r[WIDTH-1:1]};
    assign accept = in_valid & in_ready;
    assign last   = (state == ST_CALC) && (count == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)    state_nxt = ST_CALC;
            ST_CALC: if (last)      state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE) && !rst;
        out_valid = (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_r     <= '0;
            a_r     <= '0;
            q_r     <= '0;
            q_1     <= 1'b0;
            count   <= '0;
            product <= '0;
        end else if (accept) begin
            m_r   <= {a[WIDTH-1], a};
            a_r   <= '0;
            q_r   <= b;
            q_1   <= 1'b0;
            count <= CW'(WIDTH);
        end else if (state == ST_CALC) begin
            a_r   <= a_sh;
            q_r   <= q_sh;
            q_1   <= q_r[0];
            count <= count - CW'(1);
            if (last) product <= {a_sh[WIDTH-1:0], q_sh};
        end
    end

endmodule

// File: tb/tb_booth_mult.sv
// Directed checks of the Booth multiplier: reset, latency, corner products,
// backpressure, mid-operation reset and a short back-to-back random run.
module tb_booth_mult;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] product;

    int checks = 0;
    int errors = 0;

    booth_mult #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands until accepted; leaves the bench 1ns after the acceptance edge.
    task automatic launch(input logic [W-1:0] xa, input logic [W-1:0] xb);
        int n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        check("launch_ready", 32'(in_ready), 32'd1);
        a = xa; b = xb; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 50) begin tick(); lat++; end
        check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic [2*W-1:0] exp);
        int lat;
        out_ready = 1'b1;
        launch(xa, xb);
        a = ~xa; b = ~xb;  // operands must have been captured already
        wait_out(lat);
        check({tag, "_lat"}, 32'(lat), 32'd9);
        check({tag, "_prod"}, 32'(product), 32'(exp));
        tick();
        check({tag, "_pulse"}, 32'(out_valid), 32'd0);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat, cyc, last_acc, nacc, nxfer;
        logic [2*W-1:0] held;
        logic [2*W-1:0] sb[$];
        logic signed [W-1:0] sa, sbv;
        int p;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        @(negedge clk); rst = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        do_op("3x5",       8'd3,    8'd5,    16'h000F);
        do_op("m128xm128", 8'h80,   8'h80,   16'h4000);
        do_op("m128x127",  8'h80,   8'h7F,   16'hC080);
        do_op("0xm1",      8'h00,   8'hFF,   16'h0000);
        do_op("m1xm1",     8'hFF,   8'hFF,   16'h0001);
        do_op("127xm1",    8'h7F,   8'hFF,   16'hFF81);

        // Backpressure: result frozen, extra in_valid pulses ignored.
        out_ready = 1'b0;
        launch(8'd12, 8'hFD);
        wait_out(lat);
        held = product;
        check("bp_prod", 32'(product), 32'(16'hFFDC));
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0]; a = 8'(i + 1); b = 8'(i + 2);
            tick();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_stable", 32'(product), 32'(held));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);

        // Reset after four CALC edges discards the in-flight operation.
        launch(8'd100, 8'd100);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_prod", 32'(product), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd0);
        @(negedge clk); rst = 1'b0;
        tick();
        do_op("m7x9", 8'hF9, 8'd9, 16'hFFC1);

        // Back-to-back with in_valid held high and random out_ready.
        cyc = 0; last_acc = -100; nacc = 0; nxfer = 0;
        while ((nacc < 40 || sb.size() > 0) && cyc < 5000) begin
            in_valid  = (nacc < 40);
            a = 8'($urandom); b = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                nxfer++;
                check("b2b_prod", 32'(product), 32'(sb.pop_front()));
            end
            if (in_valid && in_ready) begin
                sa = a; sbv = b;
                p = int'(sa) * int'(sbv);
                sb.push_back(p[2*W-1:0]);
                if (nacc > 0) check("b2b_interval_ok", 32'(cyc - last_acc >= 10), 32'd1);
                last_acc = cyc;
                nacc++;
            end
            @(posedge clk); #1; cyc++;
        end
        in_valid = 1'b0;
        check("b2b_done_in_budget", 32'(cyc < 5000), 32'd1);
        check("b2b_xfer_eq_acc", 32'(nxfer), 32'(nacc));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
